// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice: next-PC operation codes.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SEQ    = 3'd0;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RET    = 3'd4;

endpackage : pc_pkg

// File: rtl/return_stack.sv
// LIFO of return addresses. Only the pointer is reset; entry contents are
// don't-care until written. At most one push or pop is honoured per cycle,
// and a push while full or a pop while empty is ignored here (the caller
// decides what those mean).
module return_stack #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - 1'b1);
    assign top     = mem[rd_idx];
    assign do_push = push && !full && !reset;
    assign do_pop  = pop && !empty && !reset && !push;

    // Stack pointer: counts valid entries; push wins if both are requested.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + 1'b1;
        end else if (do_pop) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry storage: written only on an accepted push, never reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule : return_stack

// File: rtl/program_counter.sv
// Program counter with branch/jump/call/return sequencing and a return-address
// stack. Stack overflow on CALL and underflow on RET degrade to a sequential
// step and latch a sticky fault that only reset clears.
module program_counter
    import pc_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int OFFSET_W     = 8,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                halt,
    input  logic [OP_W-1:0]     op,
    input  logic [OFFSET_W-1:0] intermediate,
    input  logic [ADDR_W-1:0]   target,
    output logic [ADDR_W-1:0]   programCounter,
    output logic                stackEmpty,
    output logic                stackFull,
    output logic                fault
);

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] stack_top;
    logic              push_req;
    logic              pop_req;
    logic              fault_set;

    assign pc_plus1   = programCounter + 1'b1;
    assign offset_ext = ADDR_W'($signed(intermediate));

    // Next-PC selection and stack/fault requests; halt suppresses everything.
    always_comb begin
        pc_next   = pc_plus1;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        fault_set = 1'b0;
        if (!halt) begin
            case (op)
                OP_BRANCH: pc_next = pc_plus1 + offset_ext;
                OP_JUMP:   pc_next = target;
                OP_CALL: begin
                    if (stackFull) begin
                        fault_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        pc_next  = target;
                    end
                end
                OP_RET: begin
                    if (stackEmpty) begin
                        fault_set = 1'b1;
                    end else begin
                        pop_req = 1'b1;
                        pc_next = stack_top;
                    end
                end
                default:   pc_next = pc_plus1;
            endcase
        end
    end

    // PC register: reset beats halt, halt freezes, otherwise take the mux.
    always_ff @(posedge clock) begin
        if (reset) begin
            programCounter <= ADDR_W'(RESET_VECTOR);
        end else if (!halt) begin
            programCounter <= pc_next;
        end
    end

    // Sticky fault: set on overflow/underflow, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (fault_set) begin
            fault <= 1'b1;
        end
    end

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock   (clock),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop_req),
        .data_in (pc_plus1),
        .top     (stack_top),
        .empty   (stackEmpty),
        .full    (stackFull)
    );

endmodule : program_counter

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, program-counter width in bits.
REQ-002 SHALL have parameter OFFSET_W, default 8, signed branch-offset width in bits.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>=2).
REQ-004 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port halt  input  1  freezes all state when high.
REQ-008 SHALL have port op  input  3  next-PC operation select.
REQ-009 SHALL have port intermediate  input  OFFSET_W  signed two's-complement branch offset.
REQ-010 SHALL have port target  input  ADDR_W  absolute jump/call address.
REQ-011 SHALL have port programCounter  output  ADDR_W  registered current PC.
REQ-012 SHALL have port stackEmpty  output  1  return stack holds zero entries.
REQ-013 SHALL have port stackFull  output  1  return stack holds STACK_DEPTH entries.
REQ-014 SHALL have port fault  output  1  sticky overflow/underflow flag.

Function
REQ-015 SHALL decode op: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; codes 5-7 SHALL act as SEQ.
REQ-016 SEQ SHALL load pc+1.
REQ-017 BRANCH SHALL load pc+1+sign-extend(intermediate).
REQ-018 JUMP SHALL load target.
REQ-019 CALL SHALL push pc+1 and load target in the same cycle.
REQ-020 RET SHALL pop the top entry and load it.
REQ-021 All PC arithmetic SHALL be modulo 2^ADDR_W; wrap-around (e.g. 0x3FF+1 -> 0x000) is legal and silent.
REQ-022 programCounter, stackEmpty, stackFull and fault SHALL be registered and reflect an operation one clock after the sampling edge.
REQ-023 CALL with stackFull=1 SHALL not push, SHALL behave as SEQ, and SHALL set fault.
REQ-024 RET with stackEmpty=1 SHALL not pop, SHALL behave as SEQ, and SHALL set fault.
REQ-025 fault SHALL remain set until reset.
REQ-026 With halt=1, PC, stack contents, stack pointer and fault SHALL hold; op SHALL be ignored, with no fault set.
REQ-027 Priority SHALL be reset > halt > op.
REQ-028 Stack SHALL be LIFO with at most one push or pop per cycle; entries SHALL be retained across halt.

Reset
REQ-029 On reset, programCounter SHALL load RESET_VECTOR; stack pointer SHALL load 0, giving stackEmpty=1 and stackFull=0; fault SHALL load 0.
REQ-030 Reset asserted mid-operation, including during halt, SHALL override the pending op on that edge.
REQ-031 Stack entry contents SHALL need no reset; only the pointer is reset.

Structure
REQ-032 Op encodings (SEQ, BRANCH, JUMP, CALL, RET) SHALL live as named constants in shared package pc_pkg.
REQ-033 Return stack SHALL be sub-module return_stack, parametrised by ADDR_W and STACK_DEPTH, with push, pop, data-in, top, empty and full signals.
REQ-034 Next-PC mux and fault logic SHALL reside in program_counter.

Verification
(All scenarios use defaults unless stated.)
REQ-035 Reset, then five SEQ -> programCounter 0,1,2,3,4,5 on successive cycles; stackEmpty=1; fault=0.
REQ-036 PC=0x3FF, SEQ -> 0x000; PC=0x00A, BRANCH intermediate=0xFD (-3) -> 0x008; PC=0x3FE, BRANCH 0x05 -> 0x004.
REQ-037 PC=0x020, CALL target=0x100 -> PC 0x100, stackEmpty=0; next cycle RET -> PC 0x021, stackEmpty=1.
REQ-038 Four nested CALLs -> stackFull=1; fifth CALL at PC=p -> PC p+1, fault=1, no push; four RETs then return the addresses in reverse order.
REQ-039 From reset, RET -> PC 0x001, fault=1; a following JUMP target=0x055 -> PC 0x055 with fault still 1.
REQ-040 halt=1 with op=CALL for 3 cycles -> PC, stack and fault unchanged; reset=1 while halt=1 -> PC=RESET_VECTOR, fault=0.
